// File: rtl/fetch_pkg.sv
// Shared constants and the buffer entry type for the fetch/decode buffer.
package fetch_pkg;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam int unsigned XLen     = 32;
  localparam int unsigned OpcodeW  = 7;
  localparam int unsigned RegW     = 5;
  localparam int unsigned Funct3W  = 3;

  typedef struct packed {
    logic [XLen-1:0] pc;
    logic [XLen-1:0] pc_nxt;
    logic [XLen-1:0] instr;
  } fdb_entry_t;

endpackage

// File: rtl/fdb_field_decode.sv
// Splits the head instruction into its RISC-V fields and flags non-32-bit encodings.
module fdb_field_decode
  import fetch_pkg::*;
(
  input  logic               valid_i,
  input  logic [24:0]        instr_i,
  output logic [OpcodeW-1:0] opcode_o,
  output logic [RegW-1:0]    rd_o,
  output logic [Funct3W-1:0] funct3_o,
  output logic [RegW-1:0]    rs1_o,
  output logic [RegW-1:0]    rs2_o,
  output logic               illegal_o
);

  assign opcode_o  = instr_i[6:0];
  assign rd_o      = instr_i[11:7];
  assign funct3_o  = instr_i[14:12];
  assign rs1_o     = instr_i[19:15];
  assign rs2_o     = instr_i[24:20];
  // Only 32-bit encodings (low bits 2'b11) are legal here.
  assign illegal_o = valid_i && (instr_i[1:0] != 2'b11);

endmodule

// File: rtl/fetch_decode_buf.sv
// Two-entry in-order skid buffer between fetch and decode.
// Optional FDB_DROP_ZERO_EN: accepted all-zero words are consumed but never enqueued.
module fetch_decode_buf
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pc_nxt,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_nxt,
  output logic [31:0] out_instr,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_funct3,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_illegal
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e     state_q;
  fdb_entry_t head_q, tail_q;
  fdb_entry_t in_entry;
  logic       push, pop, enq;

  assign in_entry = '{pc: in_pc, pc_nxt: in_pc_nxt, instr: in_instr};

  // Handshake signals depend on state only, so no ready path crosses the buffer.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

`ifdef FDB_DROP_ZERO_EN
  assign enq = push && (in_instr != '0);
`else
  assign enq = push;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      state_q <= StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (enq) begin
            head_q  <= in_entry;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (enq && pop) begin
            head_q <= in_entry;
          end else if (enq) begin
            tail_q  <= in_entry;
            state_q <= StFull;
          end else if (pop) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_q  <= tail_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign out_pc     = out_valid ? head_q.pc     : '0;
  assign out_pc_nxt = out_valid ? head_q.pc_nxt : '0;
  assign out_instr  = out_valid ? head_q.instr  : NOP_INSTR;

  fdb_field_decode u_field_decode (
    .valid_i   (out_valid),
    .instr_i   (out_instr[24:0]),
    .opcode_o  (out_opcode),
    .rd_o      (out_rd),
    .funct3_o  (out_funct3),
    .rs1_o     (out_rs1),
    .rs2_o     (out_rs2),
    .illegal_o (out_illegal)
  );

endmodule

// File: tb/tb_fetch_decode_buf.sv
// Directed and randomized checks of fetch_decode_buf against a queue-based reference model.
module tb_fetch_decode_buf;

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] instr;
  } ent_t;

  logic        clk, rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_pc, in_pc_nxt, in_instr, out_pc, out_pc_nxt, out_instr;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;

  int unsigned total = 0;
  int unsigned bad   = 0;
  ent_t        model_q[$];

  fetch_decode_buf dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_pc_nxt   (in_pc_nxt),
    .in_instr    (in_instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_pc_nxt  (out_pc_nxt),
    .out_instr   (out_instr),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_funct3  (out_funct3),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ei, ep, epn;
    logic        ev;
    ev  = (model_q.size() != 0);
    ei  = ev ? model_q[0].instr  : Nop;
    ep  = ev ? model_q[0].pc     : 32'h0;
    epn = ev ? model_q[0].pc_nxt : 32'h0;
    check_val("in_ready",   32'(in_ready),   32'(model_q.size() < 2));
    check_val("out_valid",  32'(out_valid),  32'(ev));
    check_val("out_pc",     out_pc,          ep);
    check_val("out_pc_nxt", out_pc_nxt,      epn);
    check_val("out_instr",  out_instr,       ei);
    check_val("opcode",     32'(out_opcode), 32'(ei[6:0]));
    check_val("rd",         32'(out_rd),     32'(ei[11:7]));
    check_val("funct3",     32'(out_funct3), 32'(ei[14:12]));
    check_val("rs1",        32'(out_rs1),    32'(ei[19:15]));
    check_val("rs2",        32'(out_rs2),    32'(ei[24:20]));
    check_val("illegal",    32'(out_illegal), 32'(ev && (ei[1:0] != 2'b11)));
  endtask

  // Called at a falling edge: check current outputs, drive inputs, advance model and one cycle.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic fl, input logic rdy);
    bit   do_pop, do_push, drop;
    ent_t e;
    check_outputs();
    in_valid  = v;
    in_pc     = pc;
    in_pc_nxt = pc + 32'd1;
    in_instr  = instr;
    flush     = fl;
    out_ready = rdy;
    if (fl) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() != 0) && rdy;
      do_push = v && (model_q.size() < 2);
`ifdef FDB_DROP_ZERO_EN
      drop = (instr == 32'h0);
`else
      drop = 1'b0;
`endif
      if (do_pop) void'(model_q.pop_front());
      if (do_push && !drop) begin
        e.pc = pc; e.pc_nxt = pc + 32'd1; e.instr = instr;
        model_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_pc_nxt = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First word after reset: one-cycle latency and decoded fields.
    step(1'b1, 32'd1, 32'h0015_8593, 1'b0, 1'b1);
    check_val("t29_valid",  32'(out_valid),  32'd1);
    check_val("t29_pc",     out_pc,          32'd1);
    check_val("t29_rd",     32'(out_rd),     32'd11);
    check_val("t29_rs1",    32'(out_rs1),    32'd11);
    check_val("t29_opcode", 32'(out_opcode), 32'h13);
    step(1'b0, 32'd0, 32'h0, 1'b0, 1'b1);

    // Fill, stall a third offer, then drain in order.
    step(1'b1, 32'd2, 32'h0000_0113, 1'b0, 1'b0);
    step(1'b1, 32'd3, 32'h0000_0193, 1'b0, 1'b0);
    check_val("t30_full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 32'd4, 32'h0000_0213, 1'b0, 1'b0);
    check_val("t30_head_pc2", out_pc, 32'd2);
    step(1'b1, 32'd4, 32'h0000_0213, 1'b0, 1'b1);
    check_val("t30_head_pc3", out_pc, 32'd3);
    step(1'b1, 32'd4, 32'h0000_0213, 1'b0, 1'b1);
    check_val("t30_head_pc4", out_pc, 32'd4);

    // Simultaneous push and pop in ONE.
    step(1'b1, 32'd5, 32'h0000_0293, 1'b0, 1'b1);
    check_val("t31_head_pc5", out_pc, 32'd5);
    check_val("t31_ready", 32'(in_ready), 32'd1);

    // Flush while FULL with a word offered.
    step(1'b1, 32'd8, 32'h0000_0413, 1'b0, 1'b0);
    step(1'b1, 32'd9, 32'h0000_0493, 1'b1, 1'b0);
    check_val("t32_valid", 32'(out_valid), 32'd0);
    check_val("t32_instr", out_instr, Nop);
    step(1'b0, 32'd0, 32'h0, 1'b0, 1'b1);

    // Zero word followed by a real one.
    step(1'b1, 32'd0, 32'h0000_0000, 1'b0, 1'b0);
    step(1'b1, 32'd2, 32'h0204_0293, 1'b0, 1'b0);
`ifndef FDB_DROP_ZERO_EN
    check_val("t34_illegal", 32'(out_illegal), 32'd1);
`endif
    step(1'b0, 32'd0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-FULL, away from a clock edge.
    step(1'b1, 32'd10, 32'h0000_0513, 1'b0, 1'b0);
    step(1'b1, 32'd11, 32'h0000_0593, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    model_q.delete();
    #1;
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_ready", 32'(in_ready),  32'd1);
    check_val("rst_instr", out_instr,      Nop);
    check_val("rst_pc",    out_pc,         32'd0);
    check_val("rst_pcn",   out_pc_nxt,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'd12, 32'h0000_0613, 1'b0, 1'b0);
    check_val("rst_first_pc", out_pc, 32'd12);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      step($urandom_range(0, 9) < 7, $urandom,
           ($urandom_range(0, 9) == 0) ? 32'h0 : ((r[0] ? 32'h3 : 32'h0) | $urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_buf.md
FETCH_DECODE_BUF -- requirements
Module: fetch_decode_buf

Interface
REQ-001 SHALL provide parameter NOP_INSTR, default 32'h0000_0013, the instruction word presented when no entry is held.
REQ-002 SHALL provide clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide in_valid  input  1  fetch stage offers a word.
REQ-005 SHALL provide in_ready  output  1  buffer can accept a word this cycle.
REQ-006 SHALL provide in_pc, in_pc_nxt, in_instr  input  32 each  word-indexed PC, next PC, fetched instruction.
REQ-007 SHALL provide flush  input  1  synchronous discard of all held and incoming words.
REQ-008 SHALL provide out_valid  output  1  head entry valid for decode.
REQ-009 SHALL provide out_ready  input  1  decode consumes the head this cycle.
REQ-010 SHALL provide out_pc, out_pc_nxt, out_instr  output  32 each  head entry fields.
REQ-011 SHALL provide out_opcode 7, out_rd 5, out_funct3 3, out_rs1 5, out_rs2 5  outputs  split fields of out_instr.
REQ-012 SHALL provide out_illegal  output  1  out_valid and out_instr[1:0] != 2'b11.

Function
REQ-013 SHALL implement a 2-entry in-order buffer with states EMPTY, ONE, FULL.
REQ-014 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, derived from state only (no combinational path from out_ready).
REQ-016 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with new word at head; FULL+pop->ONE; otherwise hold.
REQ-017 Latency SHALL be exactly one cycle: a word pushed at edge N is at the head with out_valid=1 after edge N when buffer was EMPTY.
REQ-018 Order SHALL be preserved; no word SHALL be duplicated or dropped except by flush or REQ-026.
REQ-019 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-020 When out_valid=0, out_instr SHALL equal NOP_INSTR and out_pc, out_pc_nxt SHALL equal 0.
REQ-021 Field outputs SHALL be combinational slices of out_instr: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20].
REQ-022 flush SHALL have highest priority: next state EMPTY regardless of push/pop in the same cycle; a word offered during flush is discarded.
REQ-023 in_pc/in_pc_nxt SHALL be stored unmodified; no PC arithmetic in this block.

Reset
REQ-024 rst SHALL force state EMPTY immediately and asynchronously: out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_pc=0, out_pc_nxt=0.
REQ-025 Reset asserted mid-transfer SHALL discard all entries; the first push after release SHALL appear as head after one cycle.

Configuration
REQ-026 Macro FDB_DROP_ZERO_EN: when defined, an accepted in_instr == 32'h0 SHALL be consumed (counts as push handshake) but not enqueued and state unchanged by it; when undefined, zero words are enqueued as ordinary entries.

Structure
REQ-027 Package fetch_pkg SHALL hold NOP constant 32'h0000_0013, field width constants, and the buffer entry typedef {pc, pc_nxt, instr}.
REQ-028 One sub-module, fdb_field_decode, SHALL perform field slicing and out_illegal; state machine and storage remain in fetch_decode_buf.

Verification
REQ-029 Reset then push pc=1, instr=32'h0015_8593, out_ready=1 -> next cycle out_valid=1, out_pc=1, out_rd=11, out_rs1=11, out_opcode=7'h13.
REQ-030 out_ready=0, push pc=2 then pc=3 -> FULL, in_ready=0; third offer pc=4 not accepted; out_ready=1 -> pops pc=2, pc=3, pc=4 in order.
REQ-031 ONE with simultaneous push pc=5 and pop -> state ONE, head pc=5, no loss.
REQ-032 FULL, assert flush with in_valid=1 pc=9 -> next cycle out_valid=0, out_instr=32'h0000_0013; pc=9 never emitted.
REQ-033 FDB_DROP_ZERO_EN defined, push 32'h0 at pc=0 then 32'h0204_0293 at pc=2 -> only pc=2 emitted; undefined -> both emitted.
REQ-034 Push instr=32'h0000_0000 with macro undefined -> out_illegal=1; rst pulse mid-FULL -> outputs at reset values same cycle.
